knn_seq_ctrl: RTL and testbench

Sequencer that runs the KNN accelerator core through one classification job: core clear, query load, training-sample streaming, finish, and collection of K results. It sits between the host-side register/stream logic and the registered core wrapper, and owns every core control strobe (reset, wr_en, start, done, rd_en). Host words enter through a valid/ready stream. Results leave through a valid/ready result port.

---
 rtl/knn_seq_ctrl_if.sv | 23 ++
 rtl/knn_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_knn_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/knn_seq_ctrl_if.sv
// rtl/knn_seq_ctrl_if.sv - host stream and result port bundle for the KNN job sequencer
interface knn_seq_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 1
);
    logic [NUM_CH*DATA_WIDTH-1:0] s_data;
    logic                         s_valid;
    logic                         s_ready;
    logic [31:0]                  r_name;
    logic [DATA_WIDTH-1:0]        r_value;
    logic                         r_valid;
    logic                         r_ready;

    modport master (
        output s_data, s_valid, r_ready,
        input  s_ready, r_name, r_value, r_valid
    );

    modport slave (
        input  s_data, s_valid, r_ready,
        output s_ready, r_name, r_value, r_valid
    );
endinterface

// File: rtl/knn_seq_ctrl.sv
// rtl/knn_seq_ctrl.sv - sequences one KNN core job: clear, query load, sample stream, finish, result readout
module knn_seq_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int DIMENSIONS   = 32,
    parameter int NUM_CH       = 1,
    parameter int K            = 1,
    parameter int CLR_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 8,
    parameter int RD_LATENCY   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         job_go,
    input  logic [31:0]                  num_samples,
    knn_seq_ctrl_if.slave                host,
    output logic                         busy,
    output logic                         job_done,
    output logic                         knn_reset,
    output logic                         knn_wr_en,
    output logic                         knn_start,
    output logic                         knn_done,
    output logic                         knn_rd_en,
    output logic [NUM_CH*DATA_WIDTH-1:0] knn_dataValueIn,
    input  logic [31:0]                  knn_dataNameOut,
    input  logic [DATA_WIDTH-1:0]        knn_dataValueOut
);
    localparam int BEATS = DIMENSIONS / NUM_CH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = 16;

    if (DIMENSIONS % NUM_CH != 0) begin : g_dim_check
        $error("DIMENSIONS must be divisible by NUM_CH");
    end

    typedef enum logic [3:0] {
        IDLE, CLEAR, START, LOAD_Q, LOAD_T, FINISH, DRAIN, READ, WAIT_RD, PRESENT
    } state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [BW-1:0]                beat_q, beat_d;
    logic [31:0]                  smp_q, smp_d, nsmp_q, nsmp_d, res_q, res_d;
    logic                         s_ready_q, s_ready_d, r_valid_q, r_valid_d;
    logic                         busy_q, busy_d, job_done_q, job_done_d;
    logic                         krst_q, krst_d, wr_q, wr_d, start_q, start_d;
    logic                         done_q, done_d, rd_q, rd_d;
    logic [NUM_CH*DATA_WIDTH-1:0] din_q, din_d;
    logic [31:0]                  rname_q, rname_d;
    logic [DATA_WIDTH-1:0]        rvalue_q, rvalue_d;
    logic                         beat;

    assign beat = host.s_valid & s_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        smp_d      = smp_q;
        nsmp_d     = nsmp_q;
        res_d      = res_q;
        din_d      = beat ? host.s_data : din_q;
        rname_d    = rname_q;
        rvalue_d   = rvalue_q;
        wr_d       = beat;
        job_done_d = 1'b0;
        case (state_q)
            IDLE: if (job_go) begin
                nsmp_d  = num_samples;
                cnt_d   = '0;
                beat_d  = '0;
                smp_d   = '0;
                res_d   = '0;
                state_d = CLEAR;
            end
            CLEAR: if (cnt_q == CW'(CLR_CYCLES - 1)) begin
                cnt_d   = '0;
                state_d = START;
            end else cnt_d = cnt_q + CW'(1);
            START: state_d = LOAD_Q;
            LOAD_Q: if (beat) begin
                if (beat_q == BW'(BEATS - 1)) begin
                    beat_d  = '0;
                    state_d = (nsmp_q == 32'd0) ? FINISH : LOAD_T;
                end else beat_d = beat_q + BW'(1);
            end
            LOAD_T: if (beat) begin
                if (beat_q == BW'(BEATS - 1)) begin
                    beat_d = '0;
                    smp_d  = smp_q + 32'd1;
                    if (smp_q == nsmp_q - 32'd1) state_d = FINISH;
                end else beat_d = beat_q + BW'(1);
            end
            // First FINISH cycle lets the last registered write drain, second raises knn_done.
            FINISH: if (cnt_q == '0) cnt_d = CW'(1);
            else begin
                cnt_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
                cnt_d   = '0;
                state_d = READ;
            end else cnt_d = cnt_q + CW'(1);
            READ: state_d = WAIT_RD;
            WAIT_RD: if (cnt_q == CW'(RD_LATENCY - 1)) begin
                cnt_d    = '0;
                rname_d  = knn_dataNameOut;
                rvalue_d = knn_dataValueOut;
                state_d  = PRESENT;
            end else cnt_d = cnt_q + CW'(1);
            PRESENT: if (host.r_ready) begin
                res_d = res_q + 32'd1;
                if (res_q == 32'(K - 1)) begin
                    job_done_d = 1'b1;
                    state_d    = IDLE;
                end else state_d = READ;
            end
            default: state_d = IDLE;
        endcase
        s_ready_d = (state_d == LOAD_Q) || (state_d == LOAD_T);
        busy_d    = (state_d != IDLE);
        krst_d    = (state_d == CLEAR);
        start_d   = (state_d == START);
        done_d    = (state_d == FINISH) && (cnt_d == CW'(1));
        rd_d      = (state_d == READ);
        r_valid_d = (state_d == PRESENT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            beat_q     <= '0;
            smp_q      <= '0;
            nsmp_q     <= '0;
            res_q      <= '0;
            din_q      <= '0;
            rname_q    <= '0;
            rvalue_q   <= '0;
            s_ready_q  <= 1'b0;
            r_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            job_done_q <= 1'b0;
            krst_q     <= 1'b1;
            wr_q       <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            smp_q      <= smp_d;
            nsmp_q     <= nsmp_d;
            res_q      <= res_d;
            din_q      <= din_d;
            rname_q    <= rname_d;
            rvalue_q   <= rvalue_d;
            s_ready_q  <= s_ready_d;
            r_valid_q  <= r_valid_d;
            busy_q     <= busy_d;
            job_done_q <= job_done_d;
            krst_q     <= krst_d;
            wr_q       <= wr_d;
            start_q    <= start_d;
            done_q     <= done_d;
            rd_q       <= rd_d;
        end
    end

    assign host.s_ready    = s_ready_q;
    assign host.r_valid    = r_valid_q;
    assign host.r_name     = rname_q;
    assign host.r_value    = rvalue_q;
    assign busy            = busy_q;
    assign job_done        = job_done_q;
    assign knn_reset       = krst_q;
    assign knn_wr_en       = wr_q;
    assign knn_start       = start_q;
    assign knn_done        = done_q;
    assign knn_rd_en       = rd_q;
    assign knn_dataValueIn = din_q;
endmodule

// File: tb/tb_knn_seq_ctrl.sv
// tb/tb_knn_seq_ctrl.sv - self-checking bench for knn_seq_ctrl (one K=1 and one K=3 instance)
module tb_knn_seq_ctrl;
    localparam int DW = 32, DIM = 4, NCH = 1, CLR = 4, DRN = 8, RDL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, sel, job_go, sv, rr;
    logic [31:0] num_samples, sd, core_name;
    logic [DW-1:0] core_value;
    logic busy_a, jd_a, krst_a, wr_a, st_a, dn_a, rd_a;
    logic busy_b, jd_b, krst_b, wr_b, st_b, dn_b, rd_b;
    logic [NCH*DW-1:0] din_a, din_b;

    knn_seq_ctrl_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) if_a ();
    knn_seq_ctrl_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) if_b ();

    assign if_a.s_data  = sd;
    assign if_b.s_data  = sd;
    assign if_a.s_valid = sv & ~sel;
    assign if_b.s_valid = sv & sel;
    assign if_a.r_ready = rr & ~sel;
    assign if_b.r_ready = rr & sel;

    knn_seq_ctrl #(.DATA_WIDTH(DW), .DIMENSIONS(DIM), .NUM_CH(NCH), .K(1), .CLR_CYCLES(CLR),
                   .DRAIN_CYCLES(DRN), .RD_LATENCY(RDL)) u_dut_a (
        .clk(clk), .reset(reset), .job_go(job_go & ~sel), .num_samples(num_samples), .host(if_a),
        .busy(busy_a), .job_done(jd_a), .knn_reset(krst_a), .knn_wr_en(wr_a), .knn_start(st_a),
        .knn_done(dn_a), .knn_rd_en(rd_a), .knn_dataValueIn(din_a),
        .knn_dataNameOut(core_name), .knn_dataValueOut(core_value));

    knn_seq_ctrl #(.DATA_WIDTH(DW), .DIMENSIONS(DIM), .NUM_CH(NCH), .K(3), .CLR_CYCLES(CLR),
                   .DRAIN_CYCLES(DRN), .RD_LATENCY(RDL)) u_dut_b (
        .clk(clk), .reset(reset), .job_go(job_go & sel), .num_samples(num_samples), .host(if_b),
        .busy(busy_b), .job_done(jd_b), .knn_reset(krst_b), .knn_wr_en(wr_b), .knn_start(st_b),
        .knn_done(dn_b), .knn_rd_en(rd_b), .knn_dataValueIn(din_b),
        .knn_dataNameOut(core_name), .knn_dataValueOut(core_value));

    logic busy_m, jd_m, krst_m, wr_m, st_m, dn_m, rd_m, s_ready_m, r_valid_m;
    logic [NCH*DW-1:0] din_m;
    logic [31:0] r_name_m;
    logic [DW-1:0] r_value_m;
    assign busy_m    = sel ? busy_b : busy_a;
    assign jd_m      = sel ? jd_b : jd_a;
    assign krst_m    = sel ? krst_b : krst_a;
    assign wr_m      = sel ? wr_b : wr_a;
    assign st_m      = sel ? st_b : st_a;
    assign dn_m      = sel ? dn_b : dn_a;
    assign rd_m      = sel ? rd_b : rd_a;
    assign din_m     = sel ? din_b : din_a;
    assign s_ready_m = sel ? if_b.s_ready : if_a.s_ready;
    assign r_valid_m = sel ? if_b.r_valid : if_a.r_valid;
    assign r_name_m  = sel ? if_b.r_name : if_a.r_name;
    assign r_value_m = sel ? if_b.r_value : if_a.r_value;

    // Core model: result i is (7+i, 0x15+3i), visible only in the cycle RD_LATENCY after its read.
    logic [RDL-1:0] rd_pipe;
    int rd_idx;
    always @(posedge clk) begin
        rd_pipe <= {rd_pipe[RDL-2:0], rd_m};
        if (!busy_m) rd_idx <= 0;
        else if (rd_m) rd_idx <= rd_idx + 1;
        if (rd_pipe[RDL-2]) begin
            core_name  <= 32'(7 + rd_idx - 1);
            core_value <= 32'(32'h15 + 3 * (rd_idx - 1));
        end else begin
            core_name  <= 32'hDEAD_BEEF;
            core_value <= 32'hBAD0_0BAD;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] wr_log[$];
    int rd_log[$];
    int wr_last, krst_cnt, krst_last, st_cnt, st_cyc, dn_cnt, dn_cyc, jd_cnt, jobs, excl;
    logic busy_prev = 1'b0;
    initial begin
        wr_last = 0; krst_cnt = 0; krst_last = 0; st_cnt = 0; st_cyc = 0;
        dn_cnt = 0; dn_cyc = 0; jd_cnt = 0; jobs = 0; excl = 0;
    end
    always @(negedge clk) begin
        if (wr_m) begin wr_log.push_back(din_m); wr_last = cyc; end
        if (krst_m && reset) begin krst_cnt++; krst_last = cyc; end
        if (st_m) begin st_cnt++; st_cyc = cyc; end
        if (dn_m) begin dn_cnt++; dn_cyc = cyc; end
        if (rd_m) rd_log.push_back(cyc);
        if (jd_m) jd_cnt++;
        if (int'(wr_m) + int'(st_m) + int'(dn_m) + int'(rd_m) > 1) excl++;
        if (busy_m && !busy_prev) jobs++;
        busy_prev = busy_m;
    end

    int compared = 0, mismatched = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        bit b; int n; int stall; int bp; bit seq; int spam; int exp_wr; int exp_rd;
    } vec_t;

    task automatic run_job(input vec_t v, input string tag);
        logic [31:0] exp_q[$];
        int wbase, kbase, sbase, dbase, rbase, jbase, jobs0, ebase;
        int word = 1, res = 0, hold = 0, guard = 0, rerr = 0, derr = 0;
        bit got = 0;
        sel = v.b;
        step();
        wbase = wr_log.size(); kbase = krst_cnt; sbase = st_cnt; dbase = dn_cnt;
        rbase = rd_log.size(); jbase = jd_cnt; jobs0 = jobs; ebase = excl;
        num_samples = v.n;
        job_go = 1'b1;
        while (!got && guard < 4000) begin
            step();
            guard++;
            job_go = (guard == v.spam);
            if (jd_m) got = 1;
            sv = ($urandom_range(99) >= v.stall);
            sd = v.seq ? 32'(word) : $urandom;
            if (sv && s_ready_m) begin exp_q.push_back(sd); word++; end
            if (r_valid_m) begin
                if (r_name_m != 32'(7 + res) || r_value_m != 32'(32'h15 + 3 * res)) rerr++;
                if (hold >= v.bp) begin rr = 1'b1; res++; hold = 0; end
                else begin rr = 1'b0; hold++; end
            end else rr = 1'($urandom_range(1));
        end
        sv = 1'b0; rr = 1'b0; job_go = 1'b0;
        check($sformatf("%s job_done seen", tag), got, 1);
        repeat (2) step();
        check($sformatf("%s handshakes", tag), exp_q.size(), v.exp_wr);
        check($sformatf("%s writes", tag), wr_log.size() - wbase, v.exp_wr);
        for (int i = 0; i < exp_q.size() && wbase + i < wr_log.size(); i++) begin
            if (wr_log[wbase+i] != exp_q[i]) derr++;
            if (v.seq && wr_log[wbase+i] != 32'(i + 1)) derr++;
        end
        check($sformatf("%s write data errors", tag), derr, 0);
        check($sformatf("%s knn_reset cycles", tag), krst_cnt - kbase, CLR);
        check($sformatf("%s knn_start pulses", tag), st_cnt - sbase, 1);
        check($sformatf("%s start after clear", tag), st_cyc, krst_last + 1);
        check($sformatf("%s knn_done pulses", tag), dn_cnt - dbase, 1);
        check($sformatf("%s done after last write", tag), dn_cyc, wr_last + 1);
        check($sformatf("%s knn_rd_en pulses", tag), rd_log.size() - rbase, v.exp_rd);
        if (rd_log.size() > rbase)
            check($sformatf("%s first read cycle", tag), rd_log[rbase], dn_cyc + DRN + 1);
        check($sformatf("%s results accepted", tag), res, v.exp_rd);
        check($sformatf("%s result value errors", tag), rerr, 0);
        check($sformatf("%s job_done pulses", tag), jd_cnt - jbase, 1);
        check($sformatf("%s jobs started", tag), jobs - jobs0, 1);
        check($sformatf("%s strobe overlaps", tag), excl - ebase, 0);
        check($sformatf("%s busy after job", tag), busy_m, 0);
    endtask

    vec_t vt[7];

    initial begin
        int wbase, word, guard;
        vec_t rv;
        reset = 1'b0; sel = 1'b0; job_go = 1'b0; num_samples = '0; sv = 1'b0; sd = '0; rr = 1'b0;
        vt[0] = '{b: 0, n: 2, stall: 0,  bp: 0,  seq: 1, spam: -1, exp_wr: 12, exp_rd: 1};
        vt[1] = '{b: 0, n: 2, stall: 50, bp: 0,  seq: 1, spam: -1, exp_wr: 12, exp_rd: 1};
        vt[2] = '{b: 1, n: 2, stall: 0,  bp: 10, seq: 0, spam: -1, exp_wr: 12, exp_rd: 3};
        vt[3] = '{b: 0, n: 0, stall: 0,  bp: 0,  seq: 1, spam: -1, exp_wr: 4,  exp_rd: 1};
        vt[4] = '{b: 0, n: 1, stall: 0,  bp: 1,  seq: 1, spam: 3,  exp_wr: 8,  exp_rd: 1};
        vt[5] = '{b: 1, n: 3, stall: 30, bp: 3,  seq: 0, spam: 8,  exp_wr: 16, exp_rd: 3};
        vt[6] = '{b: 0, n: 5, stall: 40, bp: 2,  seq: 0, spam: -1, exp_wr: 24, exp_rd: 1};

        repeat (5) step();
        check("reset knn_reset", krst_m, 1);
        check("reset busy", busy_m, 0);
        check("reset s_ready", s_ready_m, 0);
        check("reset strobes", {wr_m, st_m, dn_m, rd_m, jd_m, r_valid_m}, 0);
        check("reset data/result", din_m | r_name_m | r_value_m, 0);
        sel = 1'b1;
        #1;
        check("reset knn_reset k3", krst_m, 1);
        check("reset strobes k3", {busy_m, wr_m, st_m, dn_m, rd_m, s_ready_m}, 0);
        sel = 1'b0;
        reset = 1'b1;
        #1;
        check("knn_reset before first idle clock", krst_m, 1);
        step();
        check("knn_reset after first idle clock", krst_m, 0);
        check("idle busy", busy_m, 0);

        for (int i = 0; i < 7; i++) run_job(vt[i], $sformatf("vec%0d", i));

        sel = 1'b0;
        step();
        wbase = wr_log.size();
        num_samples = 2; job_go = 1'b1; sv = 1'b1; word = 1; guard = 0;
        while (wr_log.size() - wbase < 6 && guard < 200) begin
            sd = 32'(word);
            if (s_ready_m) word++;
            step();
            job_go = 1'b0;
            guard++;
        end
        check("midjob reached write 6", wr_log.size() - wbase, 6);
        reset = 1'b0;
        #1;
        check("midjob reset busy", busy_m, 0);
        check("midjob reset s_ready", s_ready_m, 0);
        check("midjob reset knn_reset", krst_m, 1);
        check("midjob reset strobes", {wr_m, st_m, dn_m, rd_m}, 0);
        repeat (3) step();
        check("midjob no further writes", wr_log.size() - wbase, 6);
        sv = 1'b0;
        reset = 1'b1;
        step();
        run_job(vt[0], "after reset");

        for (int i = 0; i < 8; i++) begin
            rv.b = 1'($urandom_range(1));
            rv.n = $urandom_range(4);
            rv.stall = $urandom_range(60);
            rv.bp = $urandom_range(4);
            rv.seq = 1'b0;
            rv.spam = $urandom_range(30);
            rv.exp_wr = DIM * (rv.n + 1);
            rv.exp_rd = rv.b ? 3 : 1;
            run_job(rv, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
